// File: rtl/lcd_clock_gen.sv
// Programmable divided-clock and edge-strobe generator for the HD44780 bus.
// Free-running or N-period burst operation; divisor changes land only on period boundaries.
module lcd_clock_gen #(
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned DEFAULT_DIV = 6,
   parameter int unsigned BURST_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   burst_mode,
   input  logic                   start,
   input  logic [BURST_WIDTH-1:0] burst_len,
   input  logic [CNT_WIDTH-1:0]   div_in,
   input  logic                   div_valid,
   output logic                   div_ready,
   output logic                   clkdvd,
   output logic                   rise_tick,
   output logic                   fall_tick,
   output logic                   busy,
   output logic                   done
);

   localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
   localparam logic [CNT_WIDTH-1:0] DIV_MIN = CNT_WIDTH'(2);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING, BURST} state_t;

   state_t                 state;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [CNT_WIDTH-1:0]   div_act;
   logic [CNT_WIDTH-1:0]   div_pend;
   logic [BURST_WIDTH-1:0] remaining;

   logic [CNT_WIDTH-1:0]   lo_last;
   logic [CNT_WIDTH-1:0]   hi_last;
   logic [CNT_WIDTH-1:0]   div_clamped;
   logic                   boundary;

   // ceil(D/2)-1 written as (D-1)>>1 so D near 2^CNT_WIDTH cannot overflow
   assign lo_last     = (div_act - CNT_WIDTH'(1)) >> 1;
   assign hi_last     = div_act - CNT_WIDTH'(1);
   assign boundary    = (state != IDLE) && (cnt == hi_last);
   assign div_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         div_act   <= DIV_RST;
         div_pend  <= DIV_RST;
         div_ready <= 1'b1;
         remaining <= '0;
         clkdvd    <= 1'b0;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         done      <= 1'b0;
      end else begin
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         done      <= 1'b0;

         // pending divisor is applied only when no period is in progress
         if ((state == IDLE || boundary) && !div_ready) begin
            div_act   <= div_pend;
            div_ready <= 1'b1;
         end else if (div_valid && div_ready) begin
            div_pend  <= div_clamped;
            div_ready <= 1'b0;
         end

         if (state == IDLE) begin
            cnt    <= '0;
            clkdvd <= 1'b0;
            if (en && !burst_mode) begin
               state <= RUN;
            end else if (start && burst_mode && (burst_len != '0)) begin
               state     <= BURST;
               remaining <= burst_len;
            end
         end else begin
            if (boundary) begin
               cnt       <= '0;
               clkdvd    <= 1'b0;
               fall_tick <= 1'b1;
            end else begin
               cnt <= cnt + CNT_WIDTH'(1);
               if (cnt == lo_last) begin
                  clkdvd    <= 1'b1;
                  rise_tick <= 1'b1;
               end
            end

            case (state)
               RUN: begin
                  if (!en) state <= boundary ? IDLE : STOPPING;
               end
               STOPPING: begin
                  if (en)            state <= RUN;
                  else if (boundary) state <= IDLE;
               end
               BURST: begin
                  if (boundary) begin
                     remaining <= remaining - BURST_WIDTH'(1);
                     if (remaining == BURST_WIDTH'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_clock_gen.sv
// Scoreboard bench for lcd_clock_gen: a period-position reference model queues the expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_lcd_clock_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        burst_mode;
   logic        start;
   logic [7:0]  burst_len;
   logic [15:0] div_in;
   logic        div_valid;
   logic        div_ready;
   logic        clkdvd;
   logic        rise_tick;
   logic        fall_tick;
   logic        busy;
   logic        done;

   lcd_clock_gen #(.CNT_WIDTH(16), .DEFAULT_DIV(6), .BURST_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .burst_mode(burst_mode),
      .start     (start),
      .burst_len (burst_len),
      .div_in    (div_in),
      .div_valid (div_valid),
      .div_ready (div_ready),
      .clkdvd    (clkdvd),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // {clkdvd, rise_tick, fall_tick, busy, done, div_ready}
   logic [5:0] exp_q[$];

   int  n_assert = 0;
   int  n_fail   = 0;
   bit  armed    = 1'b0;
   bit  track    = 1'b0;

   // reference model state: mode 0 idle, 1 run, 2 stopping, 3 burst
   int  m_mode, m_pos, m_d, m_pend, m_rem;
   bit  m_full;

   // monitor state
   int  busy_run = 0;
   int  done_cnt = 0;

   task model_step();
      bit c, r, f, dn;
      int k, lo;
      c = 1'b0; r = 1'b0; f = 1'b0; dn = 1'b0;
      if (!rst) begin
         exp_q.delete();
         m_mode = 0; m_pos = 0; m_d = 6; m_pend = 6; m_full = 1'b0; m_rem = 0;
      end else if (m_mode == 0) begin
         if (m_full) begin
            m_d = m_pend; m_full = 1'b0;
         end else if (div_valid) begin
            m_pend = (int'(div_in) < 2) ? 2 : int'(div_in); m_full = 1'b1;
         end
         if (en && !burst_mode) begin
            m_mode = 1; m_pos = 0;
         end else if (start && burst_mode && burst_len != 8'd0) begin
            m_mode = 3; m_pos = 0; m_rem = int'(burst_len);
         end
      end else begin
         // k = cycles elapsed in the current period after this edge
         k  = m_pos + 1;
         lo = (m_d + 1) / 2;
         c  = (k >= lo) && (k < m_d);
         r  = (k == lo);
         f  = (k == m_d);
         m_pos = f ? 0 : k;
         if (f && m_full) begin
            m_d = m_pend; m_full = 1'b0;
         end else if (div_valid && !m_full) begin
            m_pend = (int'(div_in) < 2) ? 2 : int'(div_in); m_full = 1'b1;
         end
         case (m_mode)
            1: if (!en) m_mode = f ? 0 : 2;
            2: if (en) m_mode = 1; else if (f) m_mode = 0;
            default: if (f) begin
               m_rem = m_rem - 1;
               if (m_rem == 0) begin m_mode = 0; dn = 1'b1; end
            end
         endcase
      end
      exp_q.push_back({c, r, f, (m_mode != 0), dn, !m_full});
   endtask

   always @(posedge clk or negedge rst) model_step();

   task check_step();
      logic [5:0] got, e;
      if (!armed) return;
      got = {clkdvd, rise_tick, fall_tick, busy, done, div_ready};
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_underflow t=%0t got=%b required=<queued value>", $time, got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            n_fail++;
            $display("FAIL outputs t=%0t clkdvd/rise/fall/busy/done/div_ready got=%b required=%b",
                     $time, got, e);
         end
      end
      // directed burst window: length of busy and number of done pulses
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) begin
         busy_run++;
      end else if (busy_run > 0) begin
         if (track) begin
            n_assert++;
            if (busy_run != 12) begin
               n_fail++;
               $display("FAIL burst_busy_len got=%0d required=12", busy_run);
            end
            n_assert++;
            if (done_cnt != 1) begin
               n_fail++;
               $display("FAIL burst_done_count got=%0d required=1", done_cnt);
            end
         end
         busy_run = 0;
         done_cnt = 0;
      end else begin
         done_cnt = 0;
      end
   endtask

   always @(negedge clk) check_step();

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(2);
      rst = 1'b1;
   endtask

   // hold div_valid until the edge that accepts it
   task automatic load(input int d);
      bit ok;
      div_in    = 16'(d);
      div_valid = 1'b1;
      ok        = 1'b0;
      for (int i = 0; i < 300; i++) begin
         ok = div_ready;
         step(1);
         if (ok) break;
      end
      div_valid = 1'b0;
      if (!ok) begin
         $display("FAIL div_handshake_timeout got=div_ready low required=accept within 300 cycles");
         $fatal(1, "handshake timeout");
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000; i++) begin
         if (!busy) break;
         step(1);
      end
      if (busy) begin
         $display("FAIL idle_timeout got=busy high required=idle within 2000 cycles");
         $fatal(1, "idle timeout");
      end
   endtask

   task automatic burst(input int len);
      burst_len = 8'(len);
      start     = 1'b1;
      step(1);
      start     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; burst_mode = 1'b0; start = 1'b0;
      burst_len = 8'd0; div_in = 16'd0; div_valid = 1'b0;
      @(posedge clk);
      #2;
      armed = 1'b1;
      do_reset();

      // free run at the reset divisor
      en = 1'b1;
      step(30);

      // retune to 7 while running, then stop
      step(4);
      load(7);
      step(30);
      en = 1'b0;
      step(15);

      // stop during high phase at D=10, then resume while stopping
      load(10);
      en = 1'b1;
      step(17);
      en = 1'b0;
      step(3);
      en = 1'b1;
      step(10);
      en = 1'b0;
      step(30);

      // burst of 3 at D=4, then a zero-length start
      load(4);
      burst_mode = 1'b1;
      step(2);
      track = 1'b1;
      burst(3);
      step(20);
      track = 1'b0;
      burst(0);
      step(10);
      burst_mode = 1'b0;

      // clamp of 0 and 1
      load(0);
      en = 1'b1;
      step(10);
      load(1);
      step(10);
      en = 1'b0;
      step(10);

      // reset mid-burst at D=8, then a clean burst
      load(8);
      burst_mode = 1'b1;
      step(2);
      burst(4);
      step(5);
      do_reset();
      burst(2);
      step(30);
      burst_mode = 1'b0;

      // randomized operation mix
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: begin
               burst_mode = 1'b0;
               en = 1'($urandom_range(0, 1));
               step($urandom_range(1, 30));
            end
            3, 4: begin
               load($urandom_range(0, 12));
               step($urandom_range(0, 10));
            end
            5, 6: begin
               en = 1'b0;
               burst_mode = 1'b1;
               wait_idle();
               en = 1'($urandom_range(0, 1));
               burst($urandom_range(0, 4));
               step($urandom_range(1, 40));
               en = 1'b0;
            end
            7: begin
               burst_mode = 1'($urandom_range(0, 1));
               start = 1'($urandom_range(0, 1));
               burst_len = 8'($urandom_range(0, 3));
               step($urandom_range(1, 8));
               start = 1'b0;
            end
            8: begin
               if ($urandom_range(0, 3) == 0) do_reset();
               else step(3);
            end
            default: begin
               div_in = 16'($urandom_range(0, 12));
               div_valid = 1'b1;
               step(1);
               div_valid = 1'b0;
               step($urandom_range(1, 6));
            end
         endcase
      end

      en = 1'b0;
      burst_mode = 1'b0;
      step(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_clock_gen.md
Name: lcd_clock_gen

Overview:
- Programmable, runtime-reconfigurable clock/strobe generator for the HD44780 interface.
- Produces a divided clock with near-50% duty, plus single-cycle edge strobes.
- Supports two modes:
  - Free-running: gated by en.
  - Burst: emits exactly N periods, then stops. Used for E-strobe and command pacing.
- Divisor changes take effect only on period boundaries, so the output never glitches.

Parameters:
- CNT_WIDTH, 16: width of the divisor and the period counter.
- DEFAULT_DIV, 6: divisor loaded at reset (must be >= 2 and < 2^CNT_WIDTH).
- BURST_WIDTH, 8: width of the burst length.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  free-run enable; level-sensitive
- burst_mode  in  1  1 = burst mode; sampled only in IDLE
- start  in  1  burst start pulse; honoured only in IDLE with burst_mode=1
- burst_len  in  BURST_WIDTH  number of periods per burst; sampled with start
- div_in  in  CNT_WIDTH  new divisor D
- div_valid  in  1  divisor load request
- div_ready  out  1  divisor holding register empty
- clkdvd  out  1  divided clock
- rise_tick  out  1  one-cycle pulse, high in the same cycle clkdvd first reads 1
- fall_tick  out  1  one-cycle pulse, high in the same cycle clkdvd first reads 0
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (asynchronous; asserted at any time, including mid-period or mid-burst):
  - state=IDLE, cnt=0, active divisor=DEFAULT_DIV, pending register empty.
  - clkdvd=0, rise_tick=0, fall_tick=0, busy=0, done=0, div_ready=1.
- Period and duty:
  - Active divisor D; any load of 0 or 1 is clamped to 2.
  - Low phase L = ceil(D/2) cycles, high phase H = floor(D/2) cycles.
  - Each period starts low.
- Counting (RUN, STOPPING, BURST states only):
  - cnt increments on each clk edge.
  - At the edge where cnt == L-1: clkdvd<=1 and rise_tick<=1.
  - At the edge where cnt == D-1: cnt<=0, clkdvd<=0 and fall_tick<=1. This is the period boundary.
  - Ticks are registered and last exactly one cycle.
- Latency: the edge that samples en=1 (or start) in IDLE moves to RUN/BURST with cnt=0. The first rise occurs L edges later and the first fall D edges later. For D=6: rise at edge +3, fall at edge +6.
- Divisor handshake:
  - div_valid && div_ready on an edge captures div_in into the pending register, and div_ready<=0.
  - Pending is applied at the next period boundary, or on the next edge if state==IDLE; div_ready then returns to 1.
  - A new period always uses the full new D. A period in progress is never shortened or stretched.
  - div_valid while div_ready=0 is ignored; the requester must hold div_valid until accepted.
- States:
  - IDLE: clkdvd=0, cnt=0.
    - en=1 and burst_mode=0 -> RUN.
    - start=1 and burst_mode=1 and burst_len != 0 -> BURST; burst_len is captured into remaining.
    - start with burst_len=0 is ignored: no busy, no done.
    - start while burst_mode=0 is ignored.
  - RUN: continuous periods.
    - en=0 -> STOPPING. If cnt is already at the boundary on that edge, go directly to IDLE.
  - STOPPING: finish the current period.
    - At the boundary -> IDLE.
    - en=1 again -> RUN with no phase disturbance.
  - BURST: en is ignored; start is ignored.
    - Each boundary decrements remaining.
    - At the boundary where remaining==1 -> IDLE with done<=1 (same edge as the final fall_tick).
- Stop rule: clkdvd always ends low and the final period is always complete; a truncated high pulse is never allowed.
- busy is combinational from the state register. It drops on the same edge that clkdvd falls for the last time.
- Counter arithmetic is CNT_WIDTH-bit unsigned. Because the counter wraps only at D-1, overflow cannot occur.

Test Plan:
- Reset then en=1 with DEFAULT_DIV=6 -> clkdvd is 3 low / 3 high repeating. rise_tick fires at edges +3, +9, …; fall_tick at +6, +12, ….
- Load D=7 mid-high-phase while running at D=6 -> the current period completes at 6. The following periods are 4 low / 3 high. div_ready is low from capture until that boundary.
- Drop en during the high phase with D=10 -> the high phase completes. IDLE is reached at the boundary with clkdvd=0. Re-asserting en during STOPPING continues with no gap.
- Burst with burst_len=3, D=4 -> exactly 3 periods (2 low / 2 high). done pulses with the 3rd fall_tick. busy is high for exactly 12 cycles. burst_len=0 produces no activity.
- Load div_in=0 and div_in=1 -> both behave as D=2 (1 low / 1 high); rise_tick and fall_tick alternate every cycle.
- Assert rst mid-burst with D=8 at cnt=5 -> all outputs reset immediately. The divisor reverts to 6. A subsequent start begins a clean burst.
